// File: rtl/ysyx_23060203_ifu.sv
// Instruction fetch unit: single-outstanding fetch FSM with a one-entry output
// buffer, static next-PC prediction and flush/jump redirect handling.
module ysyx_23060203_ifu #(
    parameter logic [31:0] RESET_PC = 32'h3000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic [31:0] flush_dnpc,
    input  logic        jump_flush,
    input  logic [31:0] jump_dnpc,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t            state_q, state_n;
    logic [XLEN-1:0]   pc_q, pc_n;
    logic              discard_q, discard_n;
    logic [XLEN-1:0]   out_pc_q, out_pc_n;
    logic [XLEN-1:0]   out_inst_q, out_inst_n;

    logic              redirect;
    logic [XLEN-1:0]   redirect_pc;
    logic [XLEN-1:0]   imm_j;
    logic [XLEN-1:0]   imm_b;
    logic [XLEN-1:0]   pred_pc;

    assign redirect    = flush | jump_flush;
    assign redirect_pc = flush ? flush_dnpc : jump_dnpc;

    // Static prediction from the arriving word: JAL taken, backward branch taken
    assign imm_j = {{12{mem_rsp_data[31]}}, mem_rsp_data[19:12], mem_rsp_data[20],
                    mem_rsp_data[30:21], 1'b0};
    assign imm_b = {{20{mem_rsp_data[31]}}, mem_rsp_data[7], mem_rsp_data[30:25],
                    mem_rsp_data[11:8], 1'b0};

    always_comb begin
        pred_pc = pc_q + XLEN'(4);
        if (mem_rsp_data[6:2] == 5'b11011) begin
            pred_pc = pc_q + imm_j;
        end else if (mem_rsp_data[6:2] == 5'b11000 && mem_rsp_data[31]) begin
            pred_pc = pc_q + imm_b;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            discard_q  <= 1'b0;
            out_pc_q   <= '0;
            out_inst_q <= '0;
        end else begin
            state_q    <= state_n;
            pc_q       <= pc_n;
            discard_q  <= discard_n;
            out_pc_q   <= out_pc_n;
            out_inst_q <= out_inst_n;
        end
    end

    // Next-state: pc_q holds the fetch PC, and the predicted PC once buffered
    always_comb begin
        state_n    = state_q;
        pc_n       = pc_q;
        discard_n  = discard_q;
        out_pc_n   = out_pc_q;
        out_inst_n = out_inst_q;

        unique case (state_q)
            S_REQ: begin
                if (redirect) begin
                    pc_n = redirect_pc;
                end
                if (mem_req_ready) begin
                    state_n   = S_WAIT;
                    discard_n = redirect;
                end
            end
            S_WAIT: begin
                if (mem_rsp_valid) begin
                    if (discard_q) begin
                        discard_n = 1'b0;
                        state_n   = S_REQ;
                        if (redirect) begin
                            pc_n = redirect_pc;
                        end
                    end else if (redirect) begin
                        state_n = S_REQ;
                        pc_n    = redirect_pc;
                    end else begin
                        state_n    = S_HOLD;
                        out_pc_n   = pc_q;
                        out_inst_n = mem_rsp_data;
                        pc_n       = pred_pc;
                    end
                end else if (redirect) begin
                    pc_n      = redirect_pc;
                    discard_n = 1'b1;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    state_n = S_REQ;
                    pc_n    = redirect_pc;
                end else if (out_ready) begin
                    state_n = S_REQ;
                end
            end
            default: begin
                state_n = S_REQ;
            end
        endcase
    end

    assign mem_req_valid = (state_q == S_REQ);
    assign mem_req_addr  = pc_q;
    assign out_valid     = (state_q == S_HOLD) & ~flush & ~jump_flush;
    assign out_pc        = out_pc_q;
    assign out_inst      = out_inst_q;

endmodule

// File: tb/tb_ysyx_23060203_ifu.sv
// Scoreboard bench for ysyx_23060203_ifu: the bench plays memory and IDU.
module tb_ysyx_23060203_ifu;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic [31:0] flush_dnpc;
    logic        jump_flush;
    logic [31:0] jump_dnpc;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_inst;

    ysyx_23060203_ifu #(.RESET_PC(32'h3000_0000)) dut (
        .clock         (clock),
        .reset         (reset),
        .flush         (flush),
        .flush_dnpc    (flush_dnpc),
        .jump_flush    (jump_flush),
        .jump_dnpc     (jump_dnpc),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .out_ready     (out_ready),
        .out_valid     (out_valid),
        .out_pc        (out_pc),
        .out_inst      (out_inst)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t        sb[$];
    int          tests_run = 0;
    int          tests_failed = 0;
    logic [31:0] last_addr;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
    endtask

    // Memory side: accept the next request, recording its address
    task automatic mem_accept(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (mem_req_valid) begin
                ok = 1'b1;
                last_addr = mem_req_addr;
                mem_req_ready = 1'b1;
                tick();
                mem_req_ready = 1'b0;
                break;
            end
            tick();
        end
    endtask

    task automatic mem_respond(input logic [31:0] data, input logic expect_out);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = data;
        if (expect_out) sb.push_back({last_addr, data});
        tick();
        mem_rsp_valid = 1'b0;
    endtask

    // IDU side: take one offered instruction
    task automatic take_out(output logic ok, output logic [31:0] pc, output logic [31:0] inst);
        ok = 1'b0;
        pc = '0;
        inst = '0;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) begin
                ok = 1'b1;
                pc = out_pc;
                inst = out_inst;
                tick();
                break;
            end
            tick();
        end
        out_ready = 1'b0;
    endtask

    // One plain fetch with scoreboard check and next-address check
    task automatic fetch_check(input string name, input logic [31:0] exp_addr,
                               input logic [31:0] inst, input logic [31:0] exp_next);
        logic        ok;
        logic [31:0] pc, ins;
        exp_t        e;
        mem_accept(ok);
        tests_run++;
        if (!ok || last_addr !== exp_addr) begin
            tests_failed++;
            $display("FAIL %s req_addr: got %h ok=%0b, want %h", name, last_addr, ok, exp_addr);
        end
        mem_respond(inst, 1'b1);
        take_out(ok, pc, ins);
        e = (sb.size() != 0) ? sb.pop_front() : '0;
        tests_run++;
        if (!ok || pc !== e.pc || ins !== e.inst) begin
            tests_failed++;
            $display("FAIL %s out: got ok=%0b pc=%h inst=%h, want pc=%h inst=%h",
                     name, ok, pc, ins, e.pc, e.inst);
        end
        tests_run++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== exp_next) begin
            tests_failed++;
            $display("FAIL %s next_addr: got v=%0b %h, want 1 %h", name, mem_req_valid, mem_req_addr, exp_next);
        end
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h3000_0000 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: got req_v=%0b addr=%h out_v=%0b, want 1 30000000 0",
                     mem_req_valid, mem_req_addr, out_valid);
        end
    endtask

    task automatic test_basic();
        logic ok;
        mem_accept(ok);
        tests_run++;
        if (!ok || last_addr !== 32'h3000_0000 || mem_req_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_accept: got ok=%0b addr=%h req_v=%0b, want 1 30000000 0",
                     ok, last_addr, mem_req_valid);
        end
        mem_respond(32'h0000_0013, 1'b1);
        tests_run++;
        if (out_valid !== 1'b1 || out_pc !== 32'h3000_0000 || out_inst !== 32'h0000_0013) begin
            tests_failed++;
            $display("FAIL basic_latency: got v=%0b pc=%h inst=%h, want 1 30000000 00000013",
                     out_valid, out_pc, out_inst);
        end
        begin
            logic [31:0] pc, ins;
            exp_t e;
            take_out(ok, pc, ins);
            e = (sb.size() != 0) ? sb.pop_front() : '0;
            tests_run++;
            if (!ok || pc !== e.pc || ins !== e.inst) begin
                tests_failed++;
                $display("FAIL basic_out: got pc=%h inst=%h, want %h %h", pc, ins, e.pc, e.inst);
            end
        end
        tests_run++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h3000_0004) begin
            tests_failed++;
            $display("FAIL basic_next: got %h, want 30000004", mem_req_addr);
        end
    endtask

    task automatic test_jal_branch();
        do_reset();
        fetch_check("jal", 32'h3000_0000, 32'h0100_006F, 32'h3000_0010);
        fetch_check("beq_back", 32'h3000_0010, 32'hFE00_0EE3, 32'h3000_000C);
        fetch_check("nop_c", 32'h3000_000C, 32'h0000_0013, 32'h3000_0010);
        fetch_check("beq_fwd", 32'h3000_0010, 32'h0000_0463, 32'h3000_0014);
    endtask

    task automatic test_jump_wait();
        logic ok;
        mem_accept(ok);
        jump_flush = 1'b1;
        jump_dnpc  = 32'h3000_0100;
        tick();
        jump_flush = 1'b0;
        mem_respond(32'h0000_0013, 1'b0);
        tests_run++;
        if (out_valid !== 1'b0 || mem_req_valid !== 1'b1 || mem_req_addr !== 32'h3000_0100) begin
            tests_failed++;
            $display("FAIL jump_wait: got out_v=%0b req_v=%0b addr=%h, want 0 1 30000100",
                     out_valid, mem_req_valid, mem_req_addr);
        end
    endtask

    task automatic test_flush_hold();
        logic ok;
        mem_accept(ok);
        mem_respond(32'h0000_0013, 1'b0);
        out_ready  = 1'b1;
        flush      = 1'b1;
        flush_dnpc = 32'h2000_0000;
        jump_flush = 1'b1;
        jump_dnpc  = 32'h3000_0200;
        #1;
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_hold_mask: got out_v=%0b, want 0", out_valid);
        end
        tick();
        flush = 1'b0;
        jump_flush = 1'b0;
        out_ready = 1'b0;
        tests_run++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h2000_0000 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_hold_next: got req_v=%0b addr=%h out_v=%0b, want 1 20000000 0",
                     mem_req_valid, mem_req_addr, out_valid);
        end
    endtask

    task automatic test_stall();
        fetch_stall();
    endtask

    task automatic fetch_stall();
        logic        ok;
        logic [31:0] pc, ins;
        exp_t        e;
        mem_accept(ok);
        mem_respond(32'h00A0_0093, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (out_valid !== 1'b1 || out_pc !== 32'h2000_0000 || out_inst !== 32'h00A0_0093 ||
                mem_req_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL stall_%0d: got v=%0b pc=%h inst=%h req_v=%0b, want 1 20000000 00a00093 0",
                         i, out_valid, out_pc, out_inst, mem_req_valid);
            end
            tick();
        end
        take_out(ok, pc, ins);
        e = (sb.size() != 0) ? sb.pop_front() : '0;
        tests_run++;
        if (!ok || pc !== e.pc || ins !== e.inst || mem_req_addr !== 32'h2000_0004) begin
            tests_failed++;
            $display("FAIL stall_release: got pc=%h inst=%h next=%h, want %h %h 20000004",
                     pc, ins, mem_req_addr, e.pc, e.inst);
        end
    endtask

    task automatic test_redirect_req();
        flush      = 1'b1;
        flush_dnpc = 32'h3000_0400;
        tick();
        flush = 1'b0;
        tests_run++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h3000_0400) begin
            tests_failed++;
            $display("FAIL redirect_req: got v=%0b addr=%h, want 1 30000400", mem_req_valid, mem_req_addr);
        end
        jump_flush    = 1'b1;
        jump_dnpc     = 32'h3000_0500;
        mem_req_ready = 1'b1;
        tick();
        jump_flush    = 1'b0;
        mem_req_ready = 1'b0;
        tests_run++;
        if (mem_req_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL redirect_accept_wait: got req_v=%0b, want 0", mem_req_valid);
        end
        mem_respond(32'h0000_006F, 1'b0);
        tests_run++;
        if (out_valid !== 1'b0 || mem_req_valid !== 1'b1 || mem_req_addr !== 32'h3000_0500) begin
            tests_failed++;
            $display("FAIL redirect_discard: got out_v=%0b req_v=%0b addr=%h, want 0 1 30000500",
                     out_valid, mem_req_valid, mem_req_addr);
        end
    endtask

    // Sequential ALU-type words with random memory latency and IDU delay
    task automatic test_back_to_back();
        logic [31:0] exp_pc = 32'h3000_0500;
        for (int n = 0; n < 8; n++) begin
            logic        ok;
            logic [31:0] inst, pc, ins, rnd;
            exp_t        e;
            rnd  = $urandom;
            inst = {rnd[31:7], 7'b0010011};
            mem_accept(ok);
            tests_run++;
            if (!ok || last_addr !== exp_pc) begin
                tests_failed++;
                $display("FAIL b2b_%0d addr: got %h ok=%0b, want %h", n, last_addr, ok, exp_pc);
            end
            repeat ($urandom_range(0, 2)) tick();
            mem_respond(inst, 1'b1);
            repeat ($urandom_range(0, 2)) tick();
            take_out(ok, pc, ins);
            e = (sb.size() != 0) ? sb.pop_front() : '0;
            tests_run++;
            if (!ok || pc !== e.pc || ins !== e.inst) begin
                tests_failed++;
                $display("FAIL b2b_%0d out: got pc=%h inst=%h, want %h %h", n, pc, ins, e.pc, e.inst);
            end
            exp_pc = exp_pc + 32'd4;
        end
        tests_run++;
        if (sb.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: got %0d left, want 0", sb.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        flush_dnpc = '0;
        jump_flush = 1'b0;
        jump_dnpc = '0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data = '0;
        out_ready = 1'b0;
        last_addr = '0;
        test_reset();
        test_basic();
        test_jal_branch();
        test_jump_wait();
        test_flush_hold();
        test_stall();
        test_redirect_req();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
